hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline sequencer for the 5-stage datapath. It detects load-use hazards, taken branches and multi-cycle multiplies, then drives the stage registers' hold, flush and bubble controls, including the IF/ID register's `WriteInstruction` and `Flush` inputs. It keeps a small state machine so that multi-cycle stalls and post-stall suppression are sequenced correctly.

## Interface
Parameters:
- `MUL_LATENCY`, default 4: total EX cycles a multiply occupies; must be ≥ 2.
- `REG_ADDR_W`, default 5: register-address width.

Ports:
- `Clk`, in, 1: single clock; the state register updates on posedge.
- `Rst_n`, in, 1: asynchronous, active-low reset.
- `IFID_Rs`, in, `REG_ADDR_W`: rs field of the instruction in ID.
- `IFID_Rt`, in, `REG_ADDR_W`: rt field of the instruction in ID.
- `IFID_UsesRt`, in, 1: the ID instruction reads rt as a source.
- `IDEX_MemRead`, in, 1: the instruction in EX is a load.
- `IDEX_Rt`, in, `REG_ADDR_W`: destination of the load in EX.
- `IDEX_MulStart`, in, 1: the instruction in EX is a multiply, first EX cycle.
- `EX_BranchTaken`, in, 1: a branch or jump resolved taken in EX this cycle.
- `PCWrite`, out, 1: 1 = PC updates at the next posedge.
- `IFID_Hold`, out, 1: drives IF/ID `WriteInstruction`; 1 = IF/ID keeps its contents.
- `IFID_Flush`, out, 1: drives IF/ID `Flush`; 1 = the instruction leaving IF/ID is zeroed.
- `IDEX_Bubble`, out, 1: 1 = zero the control fields loaded into ID/EX.
- `EX_Hold`, out, 1: 1 = hold ID/EX and the EX operands (multiply in progress).
- `State`, out, 2: current state, for debug.

## Operation
- States: `RUN` (00), `LOAD_STALL` (01), `MUL_BUSY` (10). Encoding 11 is unused and recovers to `RUN`.
- Outputs are Mealy: combinational from the state and the current inputs. The only registered elements are the state and the multiply counter `mul_cnt`.
- Load-use hazard is defined as `IDEX_MemRead && IDEX_Rt != 0 && (IDEX_Rt == IFID_Rs || (IFID_UsesRt && IDEX_Rt == IFID_Rt))`.
- Default outputs (`RUN`, no events): `PCWrite`=1; `IFID_Hold`, `IFID_Flush`, `IDEX_Bubble`, `EX_Hold` all 0.
- `RUN` priority order:
  1. `EX_BranchTaken`: `IFID_Flush`=1, `IDEX_Bubble`=1, `PCWrite`=1 (target loads). Next state `RUN`. Any simultaneous load-use hazard is ignored.
  2. `IDEX_MulStart`: `PCWrite`=0, `IFID_Hold`=1, `EX_Hold`=1. Load `mul_cnt` = `MUL_LATENCY`-2. Next state `MUL_BUSY`.
  3. Load-use hazard: `PCWrite`=0, `IFID_Hold`=1, `IDEX_Bubble`=1. Next state `LOAD_STALL`.
- `LOAD_STALL`:
  - Outputs are at their defaults; hazard detection is suppressed for this one cycle.
  - `EX_BranchTaken` still applies its flush outputs.
  - Next state is always `RUN`.
- `MUL_BUSY`:
  - `PCWrite`=0, `IFID_Hold`=1, `EX_Hold`=1.
  - `EX_BranchTaken` and `IDEX_MemRead` are ignored, because EX holds the multiply.
  - If `mul_cnt`==0, next state is `RUN`; otherwise `mul_cnt` decrements.
- `IDEX_MulStart` and `IDEX_MemRead` asserted together is illegal. The multiply path wins.
- Width rules: `mul_cnt` is `$clog2(MUL_LATENCY)` bits wide. Register 0 never causes a hazard.

## Timing
- Reset (`Rst_n`=0, asynchronous): state = `RUN`, `mul_cnt` = 0. Outputs take the default `RUN` values immediately, subject to inputs.
- Reset asserted during `MUL_BUSY` or `LOAD_STALL` aborts the stall at once; no pending hold survives.
- Latency:
  - Load-use costs exactly 1 bubble cycle.
  - A multiply holds fetch for `MUL_LATENCY` cycles total: the `RUN` detect cycle plus `MUL_LATENCY`-1 `MUL_BUSY` cycles.
  - A taken branch costs 2 squashed slots in 0 extra cycles.
- Outputs must settle before the posedge at which the IF/ID and ID/EX registers sample.
- Back-to-back multiplies: a new `IDEX_MulStart` is only honoured in `RUN`, i.e. on the cycle after `MUL_BUSY` exits.

## Structure
- Shared package `pipeline_ctrl_pkg` holds:
  - the state localparams `ST_RUN`, `ST_LOAD_STALL`, `ST_MUL_BUSY`;
  - `REG_ADDR_W`;
  - the constant for register-0 exclusion.
- One sub-module, `load_use_detect`: a purely combinational comparator producing the hazard bit. It is reused by the future forwarding unit.

## Test plan
- Reset then idle: release `Rst_n` with all inputs at 0 → `PCWrite`=1, all other outputs 0, `State`=00.
- Load-use on rs: `IDEX_MemRead`=1, `IDEX_Rt`=8, `IFID_Rs`=8 → one cycle of `PCWrite`=0, `IFID_Hold`=1, `IDEX_Bubble`=1; next cycle `State`=01 with outputs at default; then `RUN`.
- Load-use masked cases:
  - `IDEX_Rt`=0 matching `IFID_Rs`=0 → no stall.
  - `IDEX_Rt`=9 matching `IFID_Rt`=9 with `IFID_UsesRt`=0 → no stall.
- Branch beats hazard: `EX_BranchTaken`=1 together with a load-use match → `IFID_Flush`=1, `IDEX_Bubble`=1, `PCWrite`=1, `IFID_Hold`=0; state stays `RUN`.
- Multiply with `MUL_LATENCY`=4: pulse `IDEX_MulStart` → `EX_Hold`=1 and `PCWrite`=0 for exactly 4 cycles; `EX_BranchTaken` pulsed mid-stall is ignored; `RUN` on the 5th cycle.
- Reset mid-multiply: drop `Rst_n` in the 2nd `MUL_BUSY` cycle → `EX_Hold`=0 and `State`=00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared pipeline-control constants
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] ST_RUN        = 2'b00;
  localparam logic [1:0] ST_LOAD_STALL = 2'b01;
  localparam logic [1:0] ST_MUL_BUSY   = 2'b10;

  // r0 is hardwired to zero, so a load targeting it never produces a dependency
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use dependency comparator
module load_use_detect #(
  parameter int REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] ifid_rs_i,
  input  logic [REG_ADDR_W-1:0] ifid_rt_i,
  input  logic                  ifid_uses_rt_i,
  input  logic                  idex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] idex_rt_i,
  output logic                  hazard_o
);
  import pipeline_ctrl_pkg::REG_ZERO;

  logic dest_live;
  logic rs_match;
  logic rt_match;

  assign dest_live = idex_mem_read_i && (idex_rt_i != REG_ADDR_W'(REG_ZERO));
  assign rs_match  = (idex_rt_i == ifid_rs_i);
  assign rt_match  = ifid_uses_rt_i && (idex_rt_i == ifid_rt_i);
  assign hazard_o  = dest_live && (rs_match || rt_match);

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline sequencer for load-use, branch and multiply stalls
module hazard_control_unit #(
  parameter int MUL_LATENCY = 4,
  parameter int REG_ADDR_W  = pipeline_ctrl_pkg::REG_ADDR_W
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [REG_ADDR_W-1:0] IFID_Rs,
  input  logic [REG_ADDR_W-1:0] IFID_Rt,
  input  logic                  IFID_UsesRt,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  input  logic                  IDEX_MulStart,
  input  logic                  EX_BranchTaken,
  output logic                  PCWrite,
  output logic                  IFID_Hold,
  output logic                  IFID_Flush,
  output logic                  IDEX_Bubble,
  output logic                  EX_Hold,
  output logic [1:0]            State
);
  import pipeline_ctrl_pkg::ST_RUN;
  import pipeline_ctrl_pkg::ST_LOAD_STALL;
  import pipeline_ctrl_pkg::ST_MUL_BUSY;

  localparam int CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  // The RUN detect cycle is the first of the MUL_LATENCY hold cycles, and
  // MUL_BUSY exits on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 2);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic             load_use;

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use_detect (
    .ifid_rs_i      (IFID_Rs),
    .ifid_rt_i      (IFID_Rt),
    .ifid_uses_rt_i (IFID_UsesRt),
    .idex_mem_read_i(IDEX_MemRead),
    .idex_rt_i      (IDEX_Rt),
    .hazard_o       (load_use)
  );

  always_comb begin
    state_d     = state_q;
    mul_cnt_d   = mul_cnt_q;
    PCWrite     = 1'b1;
    IFID_Hold   = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    EX_Hold     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (EX_BranchTaken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
        end else if (IDEX_MulStart) begin
          PCWrite   = 1'b0;
          IFID_Hold = 1'b1;
          EX_Hold   = 1'b1;
          mul_cnt_d = MUL_LOAD;
          state_d   = ST_MUL_BUSY;
        end else if (load_use) begin
          PCWrite     = 1'b0;
          IFID_Hold   = 1'b1;
          IDEX_Bubble = 1'b1;
          state_d     = ST_LOAD_STALL;
        end
      end

      // The bubble now sits in EX, so the old load must not re-trigger a stall.
      ST_LOAD_STALL: begin
        if (EX_BranchTaken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
        end
        state_d = ST_RUN;
      end

      ST_MUL_BUSY: begin
        PCWrite   = 1'b0;
        IFID_Hold = 1'b1;
        EX_Hold   = 1'b1;
        if (mul_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          mul_cnt_d = mul_cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

  localparam int LAT = 4;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [4:0] IFID_Rs = '0;
  logic [4:0] IFID_Rt = '0;
  logic       IFID_UsesRt = 1'b0;
  logic       IDEX_MemRead = 1'b0;
  logic [4:0] IDEX_Rt = '0;
  logic       IDEX_MulStart = 1'b0;
  logic       EX_BranchTaken = 1'b0;
  logic       PCWrite, IFID_Hold, IFID_Flush, IDEX_Bubble, EX_Hold;
  logic [1:0] State;

  int total = 0;
  int bad = 0;

  // model: remaining MUL_BUSY cycles, and whether the previous cycle started a load stall
  int m_busy = 0;
  bit m_sup = 1'b0;

  hazard_control_unit #(
    .MUL_LATENCY(LAT),
    .REG_ADDR_W (5)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .IFID_Rs       (IFID_Rs),
    .IFID_Rt       (IFID_Rt),
    .IFID_UsesRt   (IFID_UsesRt),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_Rt       (IDEX_Rt),
    .IDEX_MulStart (IDEX_MulStart),
    .EX_BranchTaken(EX_BranchTaken),
    .PCWrite       (PCWrite),
    .IFID_Hold     (IFID_Hold),
    .IFID_Flush    (IFID_Flush),
    .IDEX_Bubble   (IDEX_Bubble),
    .EX_Hold       (EX_Hold),
    .State         (State)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] dut_vec();
    return {State, PCWrite, IFID_Hold, IFID_Flush, IDEX_Bubble, EX_Hold};
  endfunction

  function automatic bit hz();
    return IDEX_MemRead && (IDEX_Rt != 5'd0) &&
           ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
  endfunction

  // vector layout: {state[1:0], pc_write, ifid_hold, ifid_flush, idex_bubble, ex_hold}
  function automatic logic [6:0] model_out();
    logic [1:0] st;
    logic pc, hold, fl, bub, exh;
    st = (m_busy > 0) ? 2'd2 : (m_sup ? 2'd1 : 2'd0);
    pc = 1'b1; hold = 1'b0; fl = 1'b0; bub = 1'b0; exh = 1'b0;
    if (m_busy > 0) begin
      pc = 1'b0; hold = 1'b1; exh = 1'b1;
    end else if (EX_BranchTaken) begin
      fl = 1'b1; bub = 1'b1;
    end else if (!m_sup && IDEX_MulStart) begin
      pc = 1'b0; hold = 1'b1; exh = 1'b1;
    end else if (!m_sup && hz()) begin
      pc = 1'b0; hold = 1'b1; bub = 1'b1;
    end
    return {st, pc, hold, fl, bub, exh};
  endfunction

  task automatic model_step();
    if (m_busy > 0) m_busy = m_busy - 1;
    else if (m_sup) m_sup = 1'b0;
    else if (EX_BranchTaken) m_sup = 1'b0;
    else if (IDEX_MulStart) m_busy = LAT - 1;
    else if (hz()) m_sup = 1'b1;
  endtask

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic row(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                     input logic uses, input logic memrd, input logic [4:0] idrt,
                     input logic mul, input logic br, input logic [6:0] exp);
    IFID_Rs = rs; IFID_Rt = rt; IFID_UsesRt = uses;
    IDEX_MemRead = memrd; IDEX_Rt = idrt;
    IDEX_MulStart = mul; EX_BranchTaken = br;
    @(negedge Clk);
    check({nm, "/model"}, dut_vec(), model_out());
    check({nm, "/lit"}, dut_vec(), exp);
    @(posedge Clk);
    model_step();
    #1;
  endtask

  initial begin
    #3;
    check("reset_hold", dut_vec(), 7'b00_1_0000);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    //   name          rs     rt     use   mrd   idrt   mul   br    expected
    row("idle",        5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b00_1_0000);
    row("lu_rs",       5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 7'b00_0_1010);
    row("lu_supp",     5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 7'b01_1_0000);
    row("lu_again",    5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 7'b00_0_1010);
    row("lu_stall2",   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b01_1_0000);
    row("lu_back",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b00_1_0000);
    row("r0_mask",     5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 7'b00_1_0000);
    row("rt_unused",   5'd3,  5'd9,  1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 7'b00_1_0000);
    row("lu_rt",       5'd3,  5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 7'b00_0_1010);
    row("lu_rt_st",    5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b01_1_0000);
    row("br_wins",     5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 7'b00_1_0110);
    row("br_after",    5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b00_1_0000);
    row("mul_det",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 7'b00_0_1001);
    row("mul_b1_br",   5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 7'b10_0_1001);
    row("mul_b2_lu",   5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 7'b10_0_1001);
    row("mul_b3",      5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b10_0_1001);
    row("mul_done",    5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b00_1_0000);
    row("lu_pre_br",   5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 7'b00_0_1010);
    row("br_in_stall", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 7'b01_1_0110);
    row("br_st_exit",  5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b00_1_0000);
    row("mul_vs_lu",   5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 7'b00_0_1001);
    row("mvl_b1",      5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b10_0_1001);
    row("mvl_b2_mul",  5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 7'b10_0_1001);
    row("mvl_b3",      5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b10_0_1001);
    row("mul_b2b",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 7'b00_0_1001);
    row("b2b_b1",      5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b10_0_1001);

    // now in the 2nd MUL_BUSY cycle: reset must abort the stall without a clock edge
    IDEX_MulStart = 1'b0;
    check("mid_mul", dut_vec(), 7'b10_0_1001);
    #2 Rst_n = 1'b0;
    m_busy = 0;
    m_sup  = 1'b0;
    #1;
    check("rst_async", dut_vec(), 7'b00_1_0000);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    row("post_rst",    5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b00_1_0000);
    row("post_rst_lu", 5'd4,  5'd4,  1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 7'b00_0_1010);
    row("post_rst_st", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 7'b01_1_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
